// File: rtl/bypass_pkg.sv
// Shared definitions for the decode-stage bypass scoreboard: producer classes,
// default latencies and the per-register scoreboard entry.
package bypass_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MUL  = 2'd2
  } cls_e;

  localparam int unsigned DEF_LD_LAT  = 2;
  localparam int unsigned DEF_MUL_LAT = 5;

  typedef struct packed {
    logic [1:0] infl;
    logic [2:0] cnt;
    logic       isld;
  } sb_entry_t;

  // Class code 3 is reserved and behaves like an ALU op.
  function automatic logic [2:0] lat_of(input logic [1:0]  cls,
                                        input int unsigned ld_lat,
                                        input int unsigned mul_lat);
    logic [2:0] lat;
    lat = 3'd0;
    case (cls)
      CLS_LOAD: lat = 3'(ld_lat);
      CLS_MUL:  lat = 3'(mul_lat);
      default:  lat = 3'd0;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/bypass_fwd_sel.sv
// Single read-port priority matcher: finds the lowest-indexed valid result bus
// whose destination equals the source register.
module bypass_fwd_sel
  import bypass_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int NUM_FWD = 9
) (
  input  logic [AW-1:0]           i_rs,
  input  logic [NUM_FWD-1:0]      i_fwd_valid,
  input  logic [NUM_FWD-1:0]      i_fwd_ready,
  input  logic [NUM_FWD*AW-1:0]   i_fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0] i_fwd_data,
  output logic                    o_hit,
  output logic                    o_ready,
  output logic [XLEN-1:0]         o_data
);

  // NOTE: every output gets a default before the loop, otherwise a no-match
  // path would leave them unassigned and infer latches.
  always_comb begin
    o_hit   = 1'b0;
    o_ready = 1'b0;
    o_data  = '0;
    // Walk from oldest to youngest so the lowest matching index wins last.
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (i_fwd_valid[i] && (i_fwd_addr[i*AW +: AW] == i_rs)) begin
        o_hit   = 1'b1;
        o_ready = i_fwd_ready[i];
        o_data  = i_fwd_data[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/bypass_scoreboard.sv
// Decode-stage scoreboard: tracks in-flight register writes with per-class
// latency countdowns, resolves RAW forwarding and raises RAW/WAW stalls.
module bypass_scoreboard
  import bypass_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int NREGS   = 32,
  parameter  int NUM_RD  = 2,
  parameter  int NUM_FWD = 9,
  parameter  int LD_LAT  = DEF_LD_LAT,
  parameter  int MUL_LAT = DEF_MUL_LAT,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                    clk_i,
  input  logic                    rsn_i,
  input  logic                    dec_valid_i,
  input  logic [NUM_RD*AW-1:0]    dec_rs_addr_i,
  input  logic [NUM_RD-1:0]       dec_rs_used_i,
  input  logic                    dec_wr_en_i,
  input  logic [AW-1:0]           dec_wr_addr_i,
  input  logic [1:0]              dec_class_i,
  input  logic [NUM_FWD-1:0]      fwd_valid_i,
  input  logic [NUM_FWD-1:0]      fwd_ready_i,
  input  logic [NUM_FWD*AW-1:0]   fwd_addr_i,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data_i,
  input  logic                    ld_miss_i,
  input  logic                    wb_en_i,
  input  logic [AW-1:0]           wb_addr_i,
  input  logic                    flush_i,
  output logic [NUM_RD-1:0]       bypass_en_o,
  output logic [NUM_RD*XLEN-1:0]  bypass_data_o,
  output logic                    stall_o,
  output logic                    stall_raw_o,
  output logic                    stall_waw_o,
  output logic [31:0]             stall_cycles_o
);

  sb_entry_t   r_sb [NREGS];
  logic [31:0] r_stall_cycles;

  logic [AW-1:0]      w_rs       [NUM_RD];
  logic [NUM_RD-1:0]  w_hit;
  logic [NUM_RD-1:0]  w_rdy;
  logic [XLEN-1:0]    w_fwd_data [NUM_RD];

  logic [NUM_RD-1:0]      w_byp_en;
  logic [NUM_RD*XLEN-1:0] w_byp_data;
  logic                   w_raw;
  logic                   w_waw;
  logic                   w_stall;
  logic [2:0]             w_lat;
  logic                   w_issue;
  logic                   w_retire;
  logic [NREGS-1:0]       w_inc;
  logic [NREGS-1:0]       w_dec;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    assign w_rs[p] = dec_rs_addr_i[p*AW +: AW];

    bypass_fwd_sel #(
      .XLEN    (XLEN),
      .AW      (AW),
      .NUM_FWD (NUM_FWD)
    ) u_fwd_sel (
      .i_rs        (w_rs[p]),
      .i_fwd_valid (fwd_valid_i),
      .i_fwd_ready (fwd_ready_i),
      .i_fwd_addr  (fwd_addr_i),
      .i_fwd_data  (fwd_data_i),
      .o_hit       (w_hit[p]),
      .o_ready     (w_rdy[p]),
      .o_data      (w_fwd_data[p])
    );
  end

  // A producer still counting down cannot be forwarded, whatever the buses say.
  always_comb begin
    w_raw      = 1'b0;
    w_byp_en   = '0;
    w_byp_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (dec_valid_i && dec_rs_used_i[p] && (w_rs[p] != '0)) begin
        if ((r_sb[w_rs[p]].infl != 2'd0) && (r_sb[w_rs[p]].cnt != 3'd0)) begin
          w_raw = 1'b1;
        end else if (w_hit[p]) begin
          if (w_rdy[p]) begin
            w_byp_en[p]                  = 1'b1;
            w_byp_data[p*XLEN +: XLEN]   = w_fwd_data[p];
          end else begin
            w_raw = 1'b1;
          end
        end
      end
    end
  end

  assign w_lat = lat_of(dec_class_i, LD_LAT, MUL_LAT);

  // A younger writer must not become forwardable ahead of the older one.
  assign w_waw = dec_valid_i && dec_wr_en_i && (dec_wr_addr_i != '0) &&
                 (r_sb[dec_wr_addr_i].infl != 2'd0) &&
                 (r_sb[dec_wr_addr_i].cnt > w_lat);

  assign w_stall  = w_raw | w_waw;
  assign w_issue  = dec_valid_i && dec_wr_en_i && !w_stall && !flush_i &&
                    (dec_wr_addr_i != '0);
  assign w_retire = wb_en_i && (wb_addr_i != '0);
  assign w_inc    = w_issue  ? (NREGS'(1) << dec_wr_addr_i) : '0;
  assign w_dec    = w_retire ? (NREGS'(1) << wb_addr_i)     : '0;

  // NOTE: the scoreboard is a flop array, not a RAM, so every entry is reset;
  // all state updates here use non-blocking assignments.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      for (int r = 0; r < NREGS; r++) r_sb[r] <= '0;
    end else if (flush_i) begin
      for (int r = 0; r < NREGS; r++) r_sb[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (w_inc[r]) begin
          r_sb[r].cnt  <= w_lat;
          r_sb[r].isld <= (dec_class_i == CLS_LOAD);
        end else if ((r_sb[r].cnt != 3'd0) && !(r_sb[r].isld && ld_miss_i)) begin
          r_sb[r].cnt <= r_sb[r].cnt - 3'd1;
        end

        if (w_inc[r] && !w_dec[r] && (r_sb[r].infl != 2'd3)) begin
          r_sb[r].infl <= r_sb[r].infl + 2'd1;
        end else if (w_dec[r] && !w_inc[r] && (r_sb[r].infl != 2'd0)) begin
          r_sb[r].infl <= r_sb[r].infl - 2'd1;
        end
      end
    end
  end

  // Stall statistics survive a flush; only reset clears them.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign bypass_en_o    = rsn_i ? w_byp_en   : '0;
  assign bypass_data_o  = rsn_i ? w_byp_data : '0;
  assign stall_raw_o    = rsn_i & w_raw;
  assign stall_waw_o    = rsn_i & w_waw;
  assign stall_o        = rsn_i & w_stall;
  assign stall_cycles_o = rsn_i ? r_stall_cycles : 32'd0;

endmodule
